harmonic_mixer: RTL

HARMONIC_MIXER -- requirements
Module: harmonic_mixer

---
 rtl/harmonic_mixer_pkg.sv | 20 ++
 rtl/harmonic_mixer_mult.sv | 33 +++
 rtl/harmonic_mixer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/harmonic_mixer_pkg.sv
// Shared definitions for the harmonic mixer slice.
// Holds the mixer FSM encoding, the sample and harmonic-index widths, and
// the starting level of the fundamental at full scale.
package addatone_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned HARM_W   = 8;

    // The fundamental starts at full scale; each later harmonic is scaled down.
    localparam logic [SAMPLE_W-1:0] LEVEL_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_READY,
        MULTIPLY,
        ACCUMULATE,
        OUTPUT
    } state_t;

endpackage

// File: rtl/harmonic_mixer_mult.sv
// mix_multiplier: registered signed16 x unsigned16 multiplier, one cycle of
// latency, shaped to map onto the iCE40 DSP block.
// Ports:
//   clock   in   system clock
//   load    in   capture a new product on this edge
//   sample  in   signed sine sample
//   level   in   unsigned 16-bit harmonic level
//   product out  (sample * level) >>> 16, held until the next load
module mix_multiplier
    import addatone_pkg::*;
(
    input  logic                       clock,
    input  logic                       load,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [SAMPLE_W-1:0] level,
    output logic signed [SAMPLE_W-1:0] product
);

    // The level is zero-extended to 17 bits so it multiplies as a positive value.
    logic signed [2*SAMPLE_W:0] full;
    logic                       unused_full;

    assign full        = sample * $signed({1'b0, level});
    // |level| < 2^16, so the shifted product always fits in 16 signed bits.
    assign unused_full = ^{full[2*SAMPLE_W], full[SAMPLE_W-1:0]};

    always_ff @(posedge clock) begin
        if (load) begin
            product <= full[2*SAMPLE_W-1:SAMPLE_W];
        end
    end

endmodule

// File: rtl/harmonic_mixer.sv
// harmonic_mixer: on each sample strobe, sums a series of harmonic sine
// samples, each weighted by a geometrically decaying level, and publishes
// the shifted sum as one mixed audio sample.
// Build option: define MIX_SATURATE_EN to clamp o_Mix_Out to the signed
// 16-bit range; otherwise the output is a plain bit-slice that wraps.
// Ports:
//   i_Clock, i_Reset      clock; synchronous active-high reset
//   i_Sample_Clock        frame start strobe
//   i_Harmonic_Count      harmonics per frame (0 behaves as 1), read live
//   i_Scale               level decay factor per harmonic, read live
//   i_Sample_Ready/Value  upstream sample handshake and signed sample
//   i_Freq_Too_High       end the frame after the current harmonic
//   o_Harmonic            index of the harmonic being requested
//   o_Next_Sample         pulse: current sample consumed
//   o_Mix_Out/o_Mix_Valid mixed sample and its update pulse
//   o_Overrun             sticky: strobe arrived mid-frame
module harmonic_mixer
    import addatone_pkg::*;
#(
    parameter int OUT_SHIFT = 3,
    parameter int ACC_WIDTH = 24
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic                i_Sample_Clock,
    input  logic [HARM_W-1:0]   i_Harmonic_Count,
    input  logic [7:0]          i_Scale,
    input  logic                i_Sample_Ready,
    input  logic [SAMPLE_W-1:0] i_Sample_Value,
    input  logic                i_Freq_Too_High,
    output logic [HARM_W-1:0]   o_Harmonic,
    output logic                o_Next_Sample,
    output logic [SAMPLE_W-1:0] o_Mix_Out,
    output logic                o_Mix_Valid,
    output logic                o_Overrun
);

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc;
    logic        [SAMPLE_W-1:0]  level;
    logic signed [SAMPLE_W-1:0]  product;
    logic                        mult_load;
    logic                        is_last;
    logic        [HARM_W-1:0]    last_idx;
    logic        [SAMPLE_W+7:0]  level_prod;
    logic        [SAMPLE_W-1:0]  mix_result;
    logic                        unused_acc;
    logic                        unused_level;

    mix_multiplier u_mult (
        .clock   (i_Clock),
        .load    (mult_load),
        .sample  (i_Sample_Value),
        .level   (level),
        .product (product)
    );

    assign last_idx     = (i_Harmonic_Count == '0) ? '0 : i_Harmonic_Count - 8'd1;
    assign is_last      = (o_Harmonic == last_idx) || i_Freq_Too_High;
    assign level_prod   = level * i_Scale;
    assign unused_acc   = ^acc;
    assign unused_level = ^level_prod[7:0];

`ifdef MIX_SATURATE_EN
    logic signed [ACC_WIDTH-1:0] shifted;

    assign shifted = acc >>> OUT_SHIFT;

    // In range only when every bit above bit 15 matches the sign bit.
    always_comb begin
        if (!shifted[ACC_WIDTH-1] && (|shifted[ACC_WIDTH-2:SAMPLE_W-1])) begin
            mix_result = 16'h7FFF;
        end else if (shifted[ACC_WIDTH-1] && !(&shifted[ACC_WIDTH-2:SAMPLE_W-1])) begin
            mix_result = 16'h8000;
        end else begin
            mix_result = shifted[SAMPLE_W-1:0];
        end
    end
`else
    assign mix_result = acc[OUT_SHIFT+SAMPLE_W-1:OUT_SHIFT];
`endif

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mult_load  = 1'b0;
        case (state)
            IDLE: begin
                if (i_Sample_Clock) begin
                    state_next = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (i_Sample_Ready) begin
                    mult_load  = 1'b1;
                    state_next = MULTIPLY;
                end
            end
            MULTIPLY:   state_next = ACCUMULATE;
            ACCUMULATE: state_next = is_last ? OUTPUT : WAIT_READY;
            OUTPUT:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; pulses default low every cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            acc           <= '0;
            level         <= '0;
            o_Harmonic    <= '0;
            o_Next_Sample <= 1'b0;
            o_Mix_Out     <= '0;
            o_Mix_Valid   <= 1'b0;
            o_Overrun     <= 1'b0;
        end else begin
            o_Next_Sample <= 1'b0;
            o_Mix_Valid   <= 1'b0;
            if (i_Sample_Clock && (state != IDLE)) begin
                o_Overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_Sample_Clock) begin
                        acc        <= '0;
                        level      <= LEVEL_INIT;
                        o_Harmonic <= '0;
                    end
                end
                ACCUMULATE: begin
                    acc           <= acc + {{(ACC_WIDTH-SAMPLE_W){product[SAMPLE_W-1]}}, product};
                    o_Next_Sample <= 1'b1;
                    if (is_last) begin
                        o_Harmonic <= '0;
                    end else begin
                        o_Harmonic <= o_Harmonic + 8'd1;
                        level      <= level_prod[SAMPLE_W+7:8];
                    end
                end
                OUTPUT: begin
                    o_Mix_Out   <= mix_result;
                    o_Mix_Valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
